// File: rtl/dbg_bvci_arb.sv
// Two-master arbiter for the debug BVCI target port. One master owns the port
// from grant until its response packet ends (or a synthetic timeout error).
module dbg_bvci_arb #(
  parameter int TIMEOUT = 256,
  parameter int TW      = 10
) (
  input  logic        clk,
  input  logic        rst_a,
  // master 0 (JTAG debug buffer path)
  input  logic [31:0] m0_dbg_address,
  input  logic [3:0]  m0_dbg_be,
  input  logic [1:0]  m0_dbg_cmd,
  input  logic        m0_dbg_cmdval,
  input  logic        m0_dbg_eop,
  input  logic [31:0] m0_dbg_wdata,
  output logic        m0_dbg_cmdack,
  output logic        m0_dbg_rspval,
  output logic [31:0] m0_dbg_rdata,
  output logic        m0_dbg_reop,
  output logic        m0_dbg_rerr,
  input  logic        m0_dbg_rspack,
  // master 1 (system-side debug master)
  input  logic [31:0] m1_dbg_address,
  input  logic [3:0]  m1_dbg_be,
  input  logic [1:0]  m1_dbg_cmd,
  input  logic        m1_dbg_cmdval,
  input  logic        m1_dbg_eop,
  input  logic [31:0] m1_dbg_wdata,
  output logic        m1_dbg_cmdack,
  output logic        m1_dbg_rspval,
  output logic [31:0] m1_dbg_rdata,
  output logic        m1_dbg_reop,
  output logic        m1_dbg_rerr,
  input  logic        m1_dbg_rspack,
  // shared target
  output logic [31:0] out_dbg_address,
  output logic [3:0]  out_dbg_be,
  output logic [1:0]  out_dbg_cmd,
  output logic        out_dbg_cmdval,
  output logic        out_dbg_eop,
  output logic [31:0] out_dbg_wdata,
  input  logic        out_dbg_cmdack,
  input  logic        in_dbg_rspval,
  input  logic [31:0] in_dbg_rdata,
  input  logic        in_dbg_reop,
  input  logic        in_dbg_rerr,
  output logic        out_dbg_rspack,
  // status
  output logic [1:0]  arb_grant,
  output logic        arb_timeout
);

  typedef enum logic [1:0] {IDLE, CMD, RSP, TERR} state_t;

  // Last timer value allowed before the synthetic error fires.
  localparam logic [TW-1:0] TLIM = TW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  state_t        state, state_nxt;
  logic [1:0]    grant, grant_nxt;
  logic          prio_m1, prio_m1_nxt;   // 1: m1 wins a tie next time
  logic [TW-1:0] timer, timer_nxt;
  logic          tmo_nxt;

  logic          sel;
  logic          g_cmdval, g_eop, g_rspack;
  logic          c_ack, r_val, r_reop, r_err;
  logic [31:0]   r_data;

  assign sel      = grant[1];
  assign g_cmdval = sel ? m1_dbg_cmdval : m0_dbg_cmdval;
  assign g_eop    = sel ? m1_dbg_eop    : m0_dbg_eop;
  assign g_rspack = sel ? m1_dbg_rspack : m0_dbg_rspack;

  // Per-master fan-out: only the owner ever sees acks or response cells.
  assign m0_dbg_cmdack = c_ack  & grant[0];
  assign m0_dbg_rspval = r_val  & grant[0];
  assign m0_dbg_reop   = r_reop & grant[0];
  assign m0_dbg_rerr   = r_err  & grant[0];
  assign m0_dbg_rdata  = grant[0] ? r_data : '0;
  assign m1_dbg_cmdack = c_ack  & grant[1];
  assign m1_dbg_rspval = r_val  & grant[1];
  assign m1_dbg_reop   = r_reop & grant[1];
  assign m1_dbg_rerr   = r_err  & grant[1];
  assign m1_dbg_rdata  = grant[1] ? r_data : '0;

  assign arb_grant = grant;

  // State, owner, round-robin pointer, response timer and timeout pulse.
  always_ff @(posedge clk or negedge rst_a) begin
    if (!rst_a) begin
      state       <= IDLE;
      grant       <= 2'b00;
      prio_m1     <= 1'b0;
      timer       <= '0;
      arb_timeout <= 1'b0;
    end else begin
      state       <= state_nxt;
      grant       <= grant_nxt;
      prio_m1     <= prio_m1_nxt;
      timer       <= timer_nxt;
      arb_timeout <= tmo_nxt;
    end
  end

  // Next-state logic plus the command mux and response routing per state.
  always_comb begin
    state_nxt       = state;
    grant_nxt       = grant;
    prio_m1_nxt     = prio_m1;
    timer_nxt       = timer;
    tmo_nxt         = 1'b0;
    out_dbg_address = '0;
    out_dbg_be      = '0;
    out_dbg_cmd     = '0;
    out_dbg_cmdval  = 1'b0;
    out_dbg_eop     = 1'b0;
    out_dbg_wdata   = '0;
    out_dbg_rspack  = 1'b0;
    c_ack           = 1'b0;
    r_val           = 1'b0;
    r_data          = '0;
    r_reop          = 1'b0;
    r_err           = 1'b0;
    case (state)
      IDLE: begin
        // Swallow any stray or late response so the target never stalls.
        out_dbg_rspack = 1'b1;
        if (m0_dbg_cmdval || m1_dbg_cmdval) begin
          state_nxt = CMD;
          if (m0_dbg_cmdval && m1_dbg_cmdval)
            grant_nxt = prio_m1 ? 2'b10 : 2'b01;
          else
            grant_nxt = m1_dbg_cmdval ? 2'b10 : 2'b01;
        end
      end
      CMD: begin
        out_dbg_address = sel ? m1_dbg_address : m0_dbg_address;
        out_dbg_be      = sel ? m1_dbg_be      : m0_dbg_be;
        out_dbg_cmd     = sel ? m1_dbg_cmd     : m0_dbg_cmd;
        out_dbg_wdata   = sel ? m1_dbg_wdata   : m0_dbg_wdata;
        out_dbg_cmdval  = g_cmdval;
        out_dbg_eop     = g_eop;
        c_ack           = out_dbg_cmdack;
        if (g_cmdval && out_dbg_cmdack && g_eop) begin
          state_nxt = RSP;
          timer_nxt = '0;
        end
      end
      RSP: begin
        r_val          = in_dbg_rspval;
        r_data         = in_dbg_rdata;
        r_reop         = in_dbg_reop;
        r_err          = in_dbg_rerr;
        out_dbg_rspack = g_rspack;
        if (in_dbg_rspval && g_rspack) begin
          timer_nxt = '0;
          if (in_dbg_reop) begin
            state_nxt   = IDLE;
            grant_nxt   = 2'b00;
            prio_m1_nxt = grant[0];
          end
        end else if (TIMEOUT != 0 && timer >= TLIM && !in_dbg_rspval) begin
          // A live rspval in the expiry cycle wins over the timeout.
          state_nxt = TERR;
          tmo_nxt   = 1'b1;
        end else if (timer != '1) begin
          timer_nxt = timer + 1'b1;
        end
      end
      TERR: begin
        // Synthetic single-cell error response; target is not acked.
        r_val  = 1'b1;
        r_reop = 1'b1;
        r_err  = 1'b1;
        if (g_rspack) begin
          state_nxt   = IDLE;
          grant_nxt   = 2'b00;
          prio_m1_nxt = grant[0];
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dbg_bvci_arb.sv
// Directed bench for dbg_bvci_arb with TIMEOUT=8.
module tb_dbg_bvci_arb;
  localparam logic [1:0] RD = 2'b01, WR = 2'b10;

  logic        clk = 1'b0, rst_a = 1'b0;
  logic [31:0] m0_dbg_address, m0_dbg_wdata, m0_dbg_rdata;
  logic [3:0]  m0_dbg_be;
  logic [1:0]  m0_dbg_cmd;
  logic        m0_dbg_cmdval, m0_dbg_eop, m0_dbg_cmdack, m0_dbg_rspval;
  logic        m0_dbg_reop, m0_dbg_rerr, m0_dbg_rspack;
  logic [31:0] m1_dbg_address, m1_dbg_wdata, m1_dbg_rdata;
  logic [3:0]  m1_dbg_be;
  logic [1:0]  m1_dbg_cmd;
  logic        m1_dbg_cmdval, m1_dbg_eop, m1_dbg_cmdack, m1_dbg_rspval;
  logic        m1_dbg_reop, m1_dbg_rerr, m1_dbg_rspack;
  logic [31:0] out_dbg_address, out_dbg_wdata, in_dbg_rdata;
  logic [3:0]  out_dbg_be;
  logic [1:0]  out_dbg_cmd, arb_grant;
  logic        out_dbg_cmdval, out_dbg_eop, out_dbg_cmdack, in_dbg_rspval;
  logic        in_dbg_reop, in_dbg_rerr, out_dbg_rspack, arb_timeout;

  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  dbg_bvci_arb #(.TIMEOUT(8), .TW(10)) dut (
    .clk(clk), .rst_a(rst_a),
    .m0_dbg_address(m0_dbg_address), .m0_dbg_be(m0_dbg_be), .m0_dbg_cmd(m0_dbg_cmd),
    .m0_dbg_cmdval(m0_dbg_cmdval), .m0_dbg_eop(m0_dbg_eop), .m0_dbg_wdata(m0_dbg_wdata),
    .m0_dbg_cmdack(m0_dbg_cmdack), .m0_dbg_rspval(m0_dbg_rspval), .m0_dbg_rdata(m0_dbg_rdata),
    .m0_dbg_reop(m0_dbg_reop), .m0_dbg_rerr(m0_dbg_rerr), .m0_dbg_rspack(m0_dbg_rspack),
    .m1_dbg_address(m1_dbg_address), .m1_dbg_be(m1_dbg_be), .m1_dbg_cmd(m1_dbg_cmd),
    .m1_dbg_cmdval(m1_dbg_cmdval), .m1_dbg_eop(m1_dbg_eop), .m1_dbg_wdata(m1_dbg_wdata),
    .m1_dbg_cmdack(m1_dbg_cmdack), .m1_dbg_rspval(m1_dbg_rspval), .m1_dbg_rdata(m1_dbg_rdata),
    .m1_dbg_reop(m1_dbg_reop), .m1_dbg_rerr(m1_dbg_rerr), .m1_dbg_rspack(m1_dbg_rspack),
    .out_dbg_address(out_dbg_address), .out_dbg_be(out_dbg_be), .out_dbg_cmd(out_dbg_cmd),
    .out_dbg_cmdval(out_dbg_cmdval), .out_dbg_eop(out_dbg_eop), .out_dbg_wdata(out_dbg_wdata),
    .out_dbg_cmdack(out_dbg_cmdack), .in_dbg_rspval(in_dbg_rspval), .in_dbg_rdata(in_dbg_rdata),
    .in_dbg_reop(in_dbg_reop), .in_dbg_rerr(in_dbg_rerr), .out_dbg_rspack(out_dbg_rspack),
    .arb_grant(arb_grant), .arb_timeout(arb_timeout)
  );

  task automatic clr_in;
    m0_dbg_address = '0; m0_dbg_be = '0; m0_dbg_cmd = '0; m0_dbg_cmdval = 0;
    m0_dbg_eop = 0; m0_dbg_wdata = '0; m0_dbg_rspack = 0;
    m1_dbg_address = '0; m1_dbg_be = '0; m1_dbg_cmd = '0; m1_dbg_cmdval = 0;
    m1_dbg_eop = 0; m1_dbg_wdata = '0; m1_dbg_rspack = 0;
    out_dbg_cmdack = 0; in_dbg_rspval = 0; in_dbg_rdata = '0; in_dbg_reop = 0; in_dbg_rerr = 0;
  endtask

  task automatic adv;
    @(posedge clk); #1;
  endtask

  // Grant master m with a single-cell read and leave it in the first RSP cycle.
  task automatic start_txn(input int m, input logic [31:0] addr);
    if (m == 0) begin
      m0_dbg_cmdval = 1; m0_dbg_address = addr; m0_dbg_cmd = RD; m0_dbg_eop = 1; m0_dbg_be = 4'hf;
    end else begin
      m1_dbg_cmdval = 1; m1_dbg_address = addr; m1_dbg_cmd = RD; m1_dbg_eop = 1; m1_dbg_be = 4'hf;
    end
    adv;
    out_dbg_cmdack = 1;
    adv;
    m0_dbg_cmdval = 0; m1_dbg_cmdval = 0; out_dbg_cmdack = 0;
  endtask

  task automatic test_reset;
    rst_a = 0; clr_in;
    repeat (2) @(posedge clk);
    #1;
    n_chk++; if (arb_grant !== 2'b00) begin n_fail++; $display("FAIL rst_grant: got %b want 00", arb_grant); end
    n_chk++; if (out_dbg_rspack !== 1'b1) begin n_fail++; $display("FAIL rst_rspack: got %b want 1", out_dbg_rspack); end
    n_chk++; if (out_dbg_cmdval !== 1'b0) begin n_fail++; $display("FAIL rst_cmdval: got %b want 0", out_dbg_cmdval); end
    n_chk++; if (arb_timeout !== 1'b0) begin n_fail++; $display("FAIL rst_timeout: got %b want 0", arb_timeout); end
    n_chk++; if ({m0_dbg_rspval, m1_dbg_rspval, m0_dbg_cmdack, m1_dbg_cmdack} !== 4'b0) begin
      n_fail++; $display("FAIL rst_master_out: got %b want 0000", {m0_dbg_rspval, m1_dbg_rspval, m0_dbg_cmdack, m1_dbg_cmdack}); end
    rst_a = 1;
    adv;
  endtask

  task automatic test_single_write;
    m0_dbg_cmdval = 1; m0_dbg_address = 32'h7fc0_0008; m0_dbg_wdata = 32'h1234_5678;
    m0_dbg_be = 4'hf; m0_dbg_cmd = WR; m0_dbg_eop = 1;
    @(negedge clk);
    n_chk++; if (out_dbg_cmdval !== 1'b0) begin n_fail++; $display("FAIL sw_latency: got %b want 0", out_dbg_cmdval); end
    adv;
    @(negedge clk);
    n_chk++; if (out_dbg_cmdval !== 1'b1) begin n_fail++; $display("FAIL sw_cmdval: got %b want 1", out_dbg_cmdval); end
    n_chk++; if (out_dbg_address !== 32'h7fc0_0008) begin n_fail++; $display("FAIL sw_addr: got %h want 7fc00008", out_dbg_address); end
    n_chk++; if (out_dbg_wdata !== 32'h1234_5678) begin n_fail++; $display("FAIL sw_wdata: got %h want 12345678", out_dbg_wdata); end
    n_chk++; if ({out_dbg_cmd, out_dbg_be, out_dbg_eop} !== {WR, 4'hf, 1'b1}) begin
      n_fail++; $display("FAIL sw_cmd_be_eop: got %b want 1011111", {out_dbg_cmd, out_dbg_be, out_dbg_eop}); end
    n_chk++; if (arb_grant !== 2'b01) begin n_fail++; $display("FAIL sw_grant: got %b want 01", arb_grant); end
    n_chk++; if (m0_dbg_cmdack !== 1'b0) begin n_fail++; $display("FAIL sw_early_ack: got %b want 0", m0_dbg_cmdack); end
    adv;
    out_dbg_cmdack = 1;
    @(negedge clk);
    n_chk++; if ({m0_dbg_cmdack, m1_dbg_cmdack} !== 2'b10) begin n_fail++; $display("FAIL sw_ack: got %b want 10", {m0_dbg_cmdack, m1_dbg_cmdack}); end
    adv;
    m0_dbg_cmdval = 0; out_dbg_cmdack = 0; m0_dbg_rspack = 1;
    @(negedge clk);
    n_chk++; if (out_dbg_cmdval !== 1'b0) begin n_fail++; $display("FAIL sw_rsp_cmdval: got %b want 0", out_dbg_cmdval); end
    adv; adv;
    in_dbg_rspval = 1; in_dbg_reop = 1; in_dbg_rdata = 32'h0;
    @(negedge clk);
    n_chk++; if ({m0_dbg_rspval, m0_dbg_reop, m1_dbg_rspval, m1_dbg_reop} !== 4'b1100) begin
      n_fail++; $display("FAIL sw_rsp_route: got %b want 1100", {m0_dbg_rspval, m0_dbg_reop, m1_dbg_rspval, m1_dbg_reop}); end
    n_chk++; if (out_dbg_rspack !== 1'b1) begin n_fail++; $display("FAIL sw_rspack: got %b want 1", out_dbg_rspack); end
    adv;
    in_dbg_rspval = 0; in_dbg_reop = 0; m0_dbg_rspack = 0;
    @(negedge clk);
    n_chk++; if (arb_grant !== 2'b00) begin n_fail++; $display("FAIL sw_release: got %b want 00", arb_grant); end
  endtask

  task automatic test_round_robin;
    logic [1:0]  exp;
    logic [31:0] rd;
    rst_a = 0; adv; rst_a = 1;
    m0_dbg_address = 32'h7fc0_0100; m1_dbg_address = 32'h7fc0_0200;
    m0_dbg_cmd = RD; m1_dbg_cmd = RD; m0_dbg_eop = 1; m1_dbg_eop = 1;
    m0_dbg_cmdval = 1; m1_dbg_cmdval = 1; m0_dbg_rspack = 1; m1_dbg_rspack = 1;
    for (int i = 0; i < 4; i++) begin
      exp = (i % 2 == 0) ? 2'b01 : 2'b10;
      rd  = 32'hA0 + 32'(i);
      adv;
      out_dbg_cmdack = 1;
      @(negedge clk);
      n_chk++; if (arb_grant !== exp) begin n_fail++; $display("FAIL rr_grant[%0d]: got %b want %b", i, arb_grant, exp); end
      n_chk++; if (out_dbg_address !== (exp[0] ? 32'h7fc0_0100 : 32'h7fc0_0200)) begin
        n_fail++; $display("FAIL rr_addr[%0d]: got %h", i, out_dbg_address); end
      adv;
      out_dbg_cmdack = 0;
      if (exp[0]) m0_dbg_cmdval = 0; else m1_dbg_cmdval = 0;
      in_dbg_rspval = 1; in_dbg_reop = 1; in_dbg_rdata = rd;
      @(negedge clk);
      n_chk++; if ({m0_dbg_rspval, m1_dbg_rspval} !== {exp[0], exp[1]}) begin
        n_fail++; $display("FAIL rr_rspval[%0d]: got %b want %b", i, {m0_dbg_rspval, m1_dbg_rspval}, {exp[0], exp[1]}); end
      n_chk++; if (m0_dbg_rdata !== (exp[0] ? rd : 32'h0) || m1_dbg_rdata !== (exp[1] ? rd : 32'h0)) begin
        n_fail++; $display("FAIL rr_rdata[%0d]: got %h/%h", i, m0_dbg_rdata, m1_dbg_rdata); end
      adv;
      in_dbg_rspval = 0; in_dbg_reop = 0;
      m0_dbg_cmdval = 1; m1_dbg_cmdval = 1;
    end
    m0_dbg_cmdval = 0; m1_dbg_cmdval = 0; m0_dbg_rspack = 0; m1_dbg_rspack = 0;
  endtask

  task automatic test_multi_cell;
    logic [31:0] a;
    logic [1:0]  c;
    m1_dbg_cmdval = 1; m1_dbg_eop = 0; m1_dbg_address = 32'h7fc0_0010; m1_dbg_cmd = RD;
    adv;
    m0_dbg_cmdval = 1; m0_dbg_eop = 1; m0_dbg_address = 32'h7fc0_0300; m0_dbg_cmd = WR;
    out_dbg_cmdack = 1;
    for (int k = 0; k < 3; k++) begin
      a = 32'h7fc0_0010 + 32'(4 * k);
      c = (k == 1) ? WR : RD;
      m1_dbg_address = a; m1_dbg_cmd = c; m1_dbg_eop = (k == 2);
      m1_dbg_wdata = 32'h5000 + 32'(k);
      @(negedge clk);
      n_chk++; if (out_dbg_address !== a || out_dbg_cmd !== c || out_dbg_eop !== (k == 2)) begin
        n_fail++; $display("FAIL mc_cell[%0d]: got %h/%b/%b", k, out_dbg_address, out_dbg_cmd, out_dbg_eop); end
      n_chk++; if (out_dbg_wdata !== 32'h5000 + 32'(k)) begin n_fail++; $display("FAIL mc_wdata[%0d]: got %h", k, out_dbg_wdata); end
      n_chk++; if ({m0_dbg_cmdack, m1_dbg_cmdack, arb_grant} !== 4'b0110) begin
        n_fail++; $display("FAIL mc_ack[%0d]: got %b want 0110", k, {m0_dbg_cmdack, m1_dbg_cmdack, arb_grant}); end
      adv;
    end
    m1_dbg_cmdval = 0; out_dbg_cmdack = 0;
    @(negedge clk);
    n_chk++; if ({out_dbg_cmdval, m0_dbg_cmdack} !== 2'b00) begin
      n_fail++; $display("FAIL mc_rsp_block: got %b want 00", {out_dbg_cmdval, m0_dbg_cmdack}); end
    adv;
    in_dbg_rspval = 1; in_dbg_reop = 1; in_dbg_rdata = 32'h77; m1_dbg_rspack = 1;
    @(negedge clk);
    n_chk++; if ({m0_dbg_rspval, m1_dbg_rspval} !== 2'b01) begin
      n_fail++; $display("FAIL mc_rsp_route: got %b want 01", {m0_dbg_rspval, m1_dbg_rspval}); end
    adv;
    in_dbg_rspval = 0; in_dbg_reop = 0; m1_dbg_rspack = 0;
    @(negedge clk);
    n_chk++; if ({arb_grant, m0_dbg_cmdack} !== 3'b000) begin
      n_fail++; $display("FAIL mc_idle: got %b want 000", {arb_grant, m0_dbg_cmdack}); end
    adv;
    out_dbg_cmdack = 1;
    @(negedge clk);
    n_chk++; if (arb_grant !== 2'b01 || out_dbg_address !== 32'h7fc0_0300 || m0_dbg_cmdack !== 1'b1) begin
      n_fail++; $display("FAIL mc_m0_next: got %b/%h/%b", arb_grant, out_dbg_address, m0_dbg_cmdack); end
    adv;
    m0_dbg_cmdval = 0; out_dbg_cmdack = 0;
    in_dbg_rspval = 1; in_dbg_reop = 1; m0_dbg_rspack = 1;
    adv;
    in_dbg_rspval = 0; in_dbg_reop = 0; m0_dbg_rspack = 0;
  endtask

  task automatic test_backpressure;
    start_txn(0, 32'h7fc0_0040);
    in_dbg_rspval = 1; in_dbg_reop = 1; in_dbg_rdata = 32'hCAFE_F00D; m0_dbg_rspack = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_chk++; if (out_dbg_rspack !== 1'b0) begin n_fail++; $display("FAIL bp_rspack[%0d]: got %b want 0", i, out_dbg_rspack); end
      n_chk++; if (m0_dbg_rspval !== 1'b1 || m0_dbg_rdata !== 32'hCAFE_F00D) begin
        n_fail++; $display("FAIL bp_hold[%0d]: got %b/%h want 1/cafef00d", i, m0_dbg_rspval, m0_dbg_rdata); end
      adv;
    end
    m0_dbg_rspack = 1;
    @(negedge clk);
    n_chk++; if (out_dbg_rspack !== 1'b1) begin n_fail++; $display("FAIL bp_release: got %b want 1", out_dbg_rspack); end
    adv;
    in_dbg_rspval = 0; in_dbg_reop = 0; m0_dbg_rspack = 0;
    @(negedge clk);
    n_chk++; if (arb_grant !== 2'b00) begin n_fail++; $display("FAIL bp_done: got %b want 00", arb_grant); end
  endtask

  task automatic test_timeout;
    start_txn(0, 32'h7fc0_0044);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n_chk++; if ({arb_timeout, m0_dbg_rspval} !== 2'b00) begin
        n_fail++; $display("FAIL to_early[%0d]: got %b want 00", i, {arb_timeout, m0_dbg_rspval}); end
      adv;
    end
    @(negedge clk);
    n_chk++; if (arb_timeout !== 1'b1) begin n_fail++; $display("FAIL to_pulse: got %b want 1", arb_timeout); end
    n_chk++; if ({m0_dbg_rspval, m0_dbg_rerr, m0_dbg_reop, m1_dbg_rspval} !== 4'b1110) begin
      n_fail++; $display("FAIL to_err_rsp: got %b want 1110", {m0_dbg_rspval, m0_dbg_rerr, m0_dbg_reop, m1_dbg_rspval}); end
    n_chk++; if (m0_dbg_rdata !== 32'h0 || out_dbg_rspack !== 1'b0) begin
      n_fail++; $display("FAIL to_rdata_ack: got %h/%b want 0/0", m0_dbg_rdata, out_dbg_rspack); end
    adv;
    m0_dbg_rspack = 1;
    @(negedge clk);
    n_chk++; if ({arb_timeout, m0_dbg_rspval} !== 2'b01) begin
      n_fail++; $display("FAIL to_one_pulse: got %b want 01", {arb_timeout, m0_dbg_rspval}); end
    adv;
    m0_dbg_rspack = 0;
    in_dbg_rspval = 1; in_dbg_reop = 1; in_dbg_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    n_chk++; if ({out_dbg_rspack, m0_dbg_rspval, m1_dbg_rspval, arb_grant} !== 5'b10000) begin
      n_fail++; $display("FAIL to_late_drain: got %b want 10000", {out_dbg_rspack, m0_dbg_rspval, m1_dbg_rspval, arb_grant}); end
    n_chk++; if (m0_dbg_rdata !== 32'h0 || m1_dbg_rdata !== 32'h0) begin
      n_fail++; $display("FAIL to_late_data: got %h/%h want 0/0", m0_dbg_rdata, m1_dbg_rdata); end
    adv;
    in_dbg_rspval = 0; in_dbg_reop = 0;
  endtask

  task automatic test_timeout_precedence;
    start_txn(0, 32'h7fc0_0048);
    repeat (7) adv;
    in_dbg_rspval = 1; in_dbg_reop = 1; in_dbg_rdata = 32'h55; m0_dbg_rspack = 1;
    @(negedge clk);
    n_chk++; if (m0_dbg_rspval !== 1'b1 || m0_dbg_rdata !== 32'h55) begin
      n_fail++; $display("FAIL tp_rsp: got %b/%h want 1/55", m0_dbg_rspval, m0_dbg_rdata); end
    adv;
    in_dbg_rspval = 0; in_dbg_reop = 0; m0_dbg_rspack = 0;
    @(negedge clk);
    n_chk++; if ({arb_timeout, arb_grant} !== 3'b000) begin
      n_fail++; $display("FAIL tp_no_timeout: got %b want 000", {arb_timeout, arb_grant}); end
  endtask

  task automatic test_reset_mid;
    start_txn(1, 32'h7fc0_004c);
    adv;
    rst_a = 0;
    in_dbg_rspval = 1; in_dbg_reop = 1; in_dbg_rdata = 32'h99; m1_dbg_rspack = 1;
    #1;
    n_chk++; if ({arb_grant, m1_dbg_rspval, m0_dbg_rspval} !== 4'b0000) begin
      n_fail++; $display("FAIL rm_clear: got %b want 0000", {arb_grant, m1_dbg_rspval, m0_dbg_rspval}); end
    n_chk++; if (out_dbg_rspack !== 1'b1 || m1_dbg_rdata !== 32'h0) begin
      n_fail++; $display("FAIL rm_idle_out: got %b/%h want 1/0", out_dbg_rspack, m1_dbg_rdata); end
    adv;
    in_dbg_rspval = 0; in_dbg_reop = 0; m1_dbg_rspack = 0;
    rst_a = 1;
    m0_dbg_cmdval = 1; m1_dbg_cmdval = 1; m0_dbg_eop = 1; m1_dbg_eop = 1;
    adv;
    @(negedge clk);
    n_chk++; if (arb_grant !== 2'b01) begin n_fail++; $display("FAIL rm_first_m0: got %b want 01", arb_grant); end
    m0_dbg_cmdval = 0; m1_dbg_cmdval = 0;
  endtask

  initial begin
    test_reset;
    test_single_write;
    test_round_robin;
    test_multi_cell;
    test_backpressure;
    test_timeout;
    test_timeout_precedence;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
